// File: rtl/sysid_read_arbiter_if.sv
// Signal bundle between the two Avalon-MM read masters, the arbiter and the ID slave.
// The arbiter binds to the slave modport; the surrounding fabric binds to master.
interface sysid_read_arbiter_if #(
  parameter int ADDR_W = 1,
  parameter int DATA_W = 32
);
  logic              m0_read;
  logic [ADDR_W-1:0] m0_address;
  logic              m0_waitrequest;
  logic [DATA_W-1:0] m0_readdata;
  logic              m0_readdatavalid;

  logic              m1_read;
  logic [ADDR_W-1:0] m1_address;
  logic              m1_waitrequest;
  logic [DATA_W-1:0] m1_readdata;
  logic              m1_readdatavalid;

  logic [ADDR_W-1:0] s_address;
  logic [DATA_W-1:0] s_readdata;

  modport slave (
    input  m0_read, m0_address, m1_read, m1_address, s_readdata,
    output m0_waitrequest, m0_readdata, m0_readdatavalid,
    output m1_waitrequest, m1_readdata, m1_readdatavalid,
    output s_address
  );

  modport master (
    output m0_read, m0_address, m1_read, m1_address, s_readdata,
    input  m0_waitrequest, m0_readdata, m0_readdatavalid,
    input  m1_waitrequest, m1_readdata, m1_readdatavalid,
    input  s_address
  );
endinterface

// File: rtl/sysid_read_arbiter.sv
// Round-robin two-master read arbiter for the combinational system-ID slave.
// Accept one cycle after request, data one cycle later; one read per 3 cycles, losers wait.
module sysid_read_arbiter #(
  parameter int ADDR_W = 1,
  parameter int DATA_W = 32
) (
  input  logic                clock,
  input  logic                reset,
  sysid_read_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              grant_q, grant_d;
  logic              last_grant_q, last_grant_d;
  logic [ADDR_W-1:0] s_addr_q, s_addr_d;
  logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d;
  logic [DATA_W-1:0] m1_rdata_q, m1_rdata_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      s_addr_q     <= '0;
      m0_rdata_q   <= '0;
      m1_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      s_addr_q     <= s_addr_d;
      m0_rdata_q   <= m0_rdata_d;
      m1_rdata_q   <= m1_rdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    s_addr_d     = s_addr_q;
    m0_rdata_d   = m0_rdata_q;
    m1_rdata_d   = m1_rdata_q;

    case (state_q)
      IDLE: begin
        if (bus.m0_read || bus.m1_read) begin
          // On a tie the master that lost last time wins.
          if (bus.m0_read && bus.m1_read) begin
            grant_d = ~last_grant_q;
          end else begin
            grant_d = bus.m1_read;
          end
          s_addr_d = grant_d ? bus.m1_address : bus.m0_address;
          state_d  = ACCESS;
        end
      end
      ACCESS: begin
        // Only the granted master's data register moves; the other holds.
        if (grant_q) begin
          m1_rdata_d = bus.s_readdata;
        end else begin
          m0_rdata_d = bus.s_readdata;
        end
        state_d = RESP;
      end
      RESP: begin
        last_grant_d = grant_q;
        state_d      = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.s_address        = s_addr_q;
  assign bus.m0_waitrequest   = !((state_q == ACCESS) && !grant_q);
  assign bus.m1_waitrequest   = !((state_q == ACCESS) &&  grant_q);
  assign bus.m0_readdatavalid = (state_q == RESP) && !grant_q;
  assign bus.m1_readdatavalid = (state_q == RESP) &&  grant_q;
  assign bus.m0_readdata      = m0_rdata_q;
  assign bus.m1_readdata      = m1_rdata_q;

endmodule

// File: tb/tb_sysid_read_arbiter.sv
// Directed-vector bench for sysid_read_arbiter: stimulus queues expected accept/response
// cycles and data per master, a negedge monitor pops and compares them.
module tb_sysid_read_arbiter;
  localparam int          ADDR_W = 1;
  localparam int          DATA_W = 32;
  localparam logic [31:0] TS     = 32'h58DA64B9;

  typedef struct {
    int          acc;
    int          rdv;
    logic [31:0] data;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;
  int   tests = 0;
  int   fails = 0;
  exp_t q0[$];
  exp_t q1[$];

  sysid_read_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  sysid_read_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  assign bus.s_readdata = bus.s_address[0] ? TS : 32'h0000_0000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int m, input int acc, input int rdv, input logic [31:0] data);
    exp_t e;
    e.acc  = acc;
    e.rdv  = rdv;
    e.data = data;
    if (m == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic mon_port(input int m, input logic wr, input logic rdv, input logic [31:0] rd);
    exp_t e;
    int   n;
    n = (m == 0) ? q0.size() : q1.size();
    if (!wr) begin
      if (n == 0) begin
        chk($sformatf("m%0d_unexpected_accept", m), 32'(wr), 32'd1);
      end else begin
        e = (m == 0) ? q0[0] : q1[0];
        chk($sformatf("m%0d_accept_cycle", m), 32'(cyc), 32'(e.acc));
      end
    end
    if (rdv) begin
      if (n == 0) begin
        chk($sformatf("m%0d_unexpected_rdv", m), 32'(rdv), 32'd0);
      end else begin
        if (m == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        chk($sformatf("m%0d_rdv_cycle", m), 32'(cyc), 32'(e.rdv));
        chk($sformatf("m%0d_readdata", m), rd, e.data);
      end
    end
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      mon_port(0, bus.m0_waitrequest, bus.m0_readdatavalid, bus.m0_readdata);
      mon_port(1, bus.m1_waitrequest, bus.m1_readdatavalid, bus.m1_readdata);
    end
  end

  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    int         t, s, u, v, w, r;
    logic [0:0] stream_addr [4];

    stream_addr[0] = 1'b1;
    stream_addr[1] = 1'b0;
    stream_addr[2] = 1'b1;
    stream_addr[3] = 1'b1;

    bus.m0_read    = 1'b1;
    bus.m0_address = 1'b0;
    bus.m1_read    = 1'b1;
    bus.m1_address = 1'b1;
    reset          = 1'b1;

    // Reset held with both reads pending.
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("rst_m0_waitrequest", 32'(bus.m0_waitrequest), 32'd1);
      chk("rst_m1_waitrequest", 32'(bus.m1_waitrequest), 32'd1);
      chk("rst_m0_rdv", 32'(bus.m0_readdatavalid), 32'd0);
      chk("rst_m1_rdv", 32'(bus.m1_readdatavalid), 32'd0);
      chk("rst_m0_readdata", bus.m0_readdata, 32'd0);
      chk("rst_m1_readdata", bus.m1_readdata, 32'd0);
      chk("rst_s_address", 32'(bus.s_address), 32'd0);
    end

    // Tie from reset, then continuous contention: m0, m1, m0, m1.
    @(posedge clock);
    #1;
    reset = 1'b0;
    t = cyc;
    push(0, t + 1,  t + 2,  32'h0);
    push(1, t + 4,  t + 5,  TS);
    push(0, t + 7,  t + 8,  32'h0);
    push(1, t + 10, t + 11, TS);
    goto(t + 10);
    bus.m0_read = 1'b0;
    bus.m1_read = 1'b0;

    // Single m0 read of the timestamp; m1 must stay quiet and keep its data.
    s = t + 13;
    goto(s);
    bus.m0_address = 1'b1;
    bus.m0_read    = 1'b1;
    push(0, s + 1, s + 2, TS);
    goto(s + 2);
    bus.m0_read = 1'b0;
    @(negedge clock);
    chk("m1_readdata_hold", bus.m1_readdata, TS);
    chk("m0_waitrequest_after_accept", 32'(bus.m0_waitrequest), 32'd1);

    // m1 streams four back-to-back reads.
    u = s + 3;
    goto(u);
    bus.m1_address = stream_addr[0];
    bus.m1_read    = 1'b1;
    for (int k = 0; k < 4; k++) begin
      push(1, u + 3 * k + 1, u + 3 * k + 2, stream_addr[k][0] ? TS : 32'h0);
      goto(u + 3 * k + 2);
      if (k < 3) bus.m1_address = stream_addr[k + 1];
      else       bus.m1_read    = 1'b0;
    end

    // m1 drops its read in the ACCESS cycle; the response still arrives, once.
    v = u + 12;
    goto(v);
    bus.m1_address = 1'b1;
    bus.m1_read    = 1'b1;
    push(1, v + 1, v + 2, TS);
    goto(v + 1);
    bus.m1_read = 1'b0;
    goto(v + 8);

    // Reset during m0's ACCESS: the aborted read must not respond.
    w = cyc;
    bus.m0_address = 1'b1;
    bus.m0_read    = 1'b1;
    goto(w + 1);
    reset = 1'b1;
    @(negedge clock);
    chk("midrst_m0_waitrequest", 32'(bus.m0_waitrequest), 32'd1);
    chk("midrst_m0_rdv", 32'(bus.m0_readdatavalid), 32'd0);
    chk("midrst_m0_readdata", bus.m0_readdata, 32'd0);
    chk("midrst_s_address", 32'(bus.s_address), 32'd0);
    goto(w + 2);
    reset = 1'b0;
    r = cyc;
    push(0, r + 1, r + 2, TS);
    goto(r + 2);
    bus.m0_read = 1'b0;
    goto(r + 5);

    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sysid_read_arbiter.md
# sysid_read_arbiter

Two-master read arbiter for the single-slave system-ID register in the DE1_SoC_QSYS fabric. The ID slave is combinational and has one address bit: word 0 is the ID and word 1 is the build timestamp. The arbiter lets the HPS-side bridge master and the capture-pipeline control master read it without a shared interconnect. Arbitration is fair round-robin, the slave response is registered, and each master sees a standard Avalon-MM read with waitrequest and readdatavalid.

## Interface
Parameters:
- ADDR_W, 1, slave word-address width
- DATA_W, 32, read data width

Ports:
- clock  in  1  single system clock; all logic is rising-edge
- reset  in  1  asynchronous, active-high reset
- m0_read  in  1  master 0 read request; held until waitrequest is low
- m0_address  in  ADDR_W  master 0 word address; held with m0_read
- m0_waitrequest  out  1  low for exactly the cycle master 0's read is accepted
- m0_readdata  out  DATA_W  master 0 read data; valid only with m0_readdatavalid
- m0_readdatavalid  out  1  one-cycle pulse, master 0 response
- m1_read, m1_address, m1_waitrequest, m1_readdata, m1_readdatavalid: same as above, for master 1
- s_address  out  ADDR_W  address to the ID slave (registered)
- s_readdata  in  DATA_W  combinational slave data for s_address

## Operation
- FSM states: IDLE, ACCESS, RESP. Reset state is IDLE.
- IDLE:
  - If neither mN_read is high, stay in IDLE.
  - If exactly one is high, grant it.
  - If both are high, grant the master that was not granted last (last_grant).
  - On grant: latch the granted address into s_address and the granted index into grant, then go to ACCESS.
- ACCESS:
  - s_address is stable.
  - m{grant}_waitrequest = 0 (command accepted).
  - Capture s_readdata into rdata_q at the clock edge, then go to RESP.
- RESP:
  - m{grant}_readdata = rdata_q and m{grant}_readdatavalid = 1.
  - last_grant <= grant, then go to IDLE.
- mN_waitrequest = NOT (state == ACCESS AND grant == N). It is decoded from registered state only and has no combinational path from mN_read.
- The non-granted master's readdata holds its previous value; its readdatavalid stays 0.
- Read dropped by a master after the grant (protocol violation): the transaction still completes and readdatavalid still pulses. A read dropped while still in IDLE is never arbitrated.
- A new read may be presented in the RESP cycle. It is arbitrated in the following IDLE cycle.
- There are no outstanding-read queues; at most one transaction is in flight.

## Timing
- Reset values (asynchronous): state = IDLE, grant = 0, last_grant = 1 (so m0 wins the first tie), s_address = 0, rdata_q = 0, m0/m1_readdata = 0, m0/m1_readdatavalid = 0, m0/m1_waitrequest = 1.
- Latency, for a read asserted in IDLE cycle T: waitrequest goes low in T+1, readdatavalid pulses in T+2.
- Throughput: one read per 3 cycles. Under continuous contention grants alternate m0, m1, m0, …
- Reset asserted mid-transaction: the FSM returns to IDLE immediately and no readdatavalid is issued for the aborted read. After release, the pending reads are re-arbitrated with m0 first.
- s_readdata is sampled only at the end of ACCESS. Slave data must settle within one cycle of s_address.

## Test plan
- Reset: hold reset for 3 cycles with both reads high. Required: waitrequest = 1 on both masters, readdatavalid = 0, readdata = 0, s_address = 0 throughout.
- Single read: slave model returns 0x58DA64B9 for address 1 and 0x00000000 for address 0. m0 reads address 1 at cycle T. Required: m0_waitrequest = 0 at T+1 only; m0_readdatavalid = 1 with 0x58DA64B9 at T+2; m1 outputs unchanged.
- Tie: both masters read simultaneously from reset (m0 address 0, m1 address 1). Required: m0 gets 0x00000000 at T+2, and m1 is accepted at T+4 and gets 0x58DA64B9 at T+5. With continuous requests, grants alternate strictly.
- Solo streaming: m1 issues 4 back-to-back reads and m0 stays idle. Required: readdatavalid pulses every 3 cycles with correct data, and no m0 activity.
- Reset mid-op: assert reset during ACCESS for m0. Required: no m0 readdatavalid pulse. After release, m0's still-held read completes 2 cycles after the first IDLE.
- Dropped read: m1 deasserts read in the cycle after its grant. Required: m1_readdatavalid still pulses once with correct data, and there is no second transaction.
